// File: rtl/ame_solver_scheduler_if.sv
// Bus bundle between the AME parameter builders, the shared equation solver
// and the scheduler that multiplexes them. The scheduler uses the slave view;
// the requester/solver side (or a bench) uses the master view.
interface ame_solver_scheduler_if #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_BITS    = 2,
  parameter int COMP_DATA_BITS = 64
);
  logic [NUM_REQ-1:0]                           req_valid_i;
  logic [NUM_REQ-1:0]                           req_ready_o;
  logic [NUM_REQ-1:0]                           req_param6_i;
  logic [NUM_REQ-1:0][5:0][6:0][COMP_DATA_BITS-1:0] req_data_i;

  logic                                         slv_init_o;
  logic                                         slv_param6_o;
  logic [5:0][6:0][COMP_DATA_BITS-1:0]          slv_data_o;
  logic                                         slv_done_i;
  logic [5:0][COMP_DATA_BITS-1:0]               slv_data_i;

  logic                                         rsp_valid_o;
  logic [REQ_ID_BITS-1:0]                       rsp_id_o;
  logic                                         rsp_timeout_o;
  logic [5:0][COMP_DATA_BITS-1:0]               rsp_data_o;
  logic                                         busy_o;

  modport slave (
    input  req_valid_i, req_param6_i, req_data_i, slv_done_i, slv_data_i,
    output req_ready_o, slv_init_o, slv_param6_o, slv_data_o,
           rsp_valid_o, rsp_id_o, rsp_timeout_o, rsp_data_o, busy_o
  );

  modport master (
    output req_valid_i, req_param6_i, req_data_i, slv_done_i, slv_data_i,
    input  req_ready_o, slv_init_o, slv_param6_o, slv_data_o,
           rsp_valid_o, rsp_id_o, rsp_timeout_o, rsp_data_o, busy_o
  );
endinterface

// File: rtl/ame_solver_scheduler.sv
// Shares one AME equation solver between NUM_REQ requesters. A round-robin
// arbiter picks a requester, its 6x7 system is latched and handed to the
// solver with a one-cycle init pulse, and the six results (or a timeout
// abort) are returned tagged with the requester ID. After a timeout the
// scheduler drains the solver's late done before accepting new work.
module ame_solver_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_BITS    = 2,
  parameter int COMP_DATA_BITS = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ame_solver_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  typedef logic [5:0][COMP_DATA_BITS-1:0] result_t;

  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);
  localparam int SUM_BITS = REQ_ID_BITS + 1;
  localparam logic [CNT_BITS-1:0]    LAST_COUNT  = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [REQ_ID_BITS-1:0] LAST_ID     = REQ_ID_BITS'(NUM_REQ - 1);
  localparam result_t                ZERO_RESULT = '0;

  state_t                 state;
  logic [REQ_ID_BITS-1:0] rr_ptr;
  logic [REQ_ID_BITS-1:0] grant_id;
  logic [REQ_ID_BITS-1:0] winner;
  logic                   found;
  logic [SUM_BITS-1:0]    sum;
  logic [CNT_BITS-1:0]    count;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_BITS'(i);
      if (sum >= SUM_BITS'(NUM_REQ)) begin
        sum = sum - SUM_BITS'(NUM_REQ);
      end
      if (!found && bus.req_valid_i[sum[REQ_ID_BITS-1:0]]) begin
        found  = 1'b1;
        winner = sum[REQ_ID_BITS-1:0];
      end
    end
  end

  // Grant is offered to the single winner, and only while idle
  always_comb begin
    bus.req_ready_o = '0;
    if (state == IDLE && found) begin
      bus.req_ready_o = NUM_REQ'(1) << winner;
    end
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      count             <= '0;
      bus.slv_init_o    <= 1'b0;
      bus.slv_param6_o  <= 1'b0;
      bus.slv_data_o    <= '0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_id_o      <= '0;
      bus.rsp_timeout_o <= 1'b0;
      bus.rsp_data_o    <= ZERO_RESULT;
      bus.busy_o        <= 1'b0;
    end else begin
      bus.slv_init_o  <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.slv_data_o   <= bus.req_data_i[winner];
            bus.slv_param6_o <= bus.req_param6_i[winner];
            grant_id         <= winner;
            rr_ptr           <= (winner == LAST_ID) ? '0 : winner + REQ_ID_BITS'(1);
            bus.slv_init_o   <= 1'b1;
            bus.busy_o       <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          count <= count + CNT_BITS'(1);
          if (bus.slv_done_i) begin
            bus.rsp_data_o    <= bus.slv_data_i;
            bus.rsp_timeout_o <= 1'b0;
            bus.rsp_id_o      <= grant_id;
            bus.rsp_valid_o   <= 1'b1;
            state             <= RESP;
          end else if (count == LAST_COUNT) begin
            bus.rsp_data_o    <= ZERO_RESULT;
            bus.rsp_timeout_o <= 1'b1;
            bus.rsp_id_o      <= grant_id;
            bus.rsp_valid_o   <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_timeout_o) begin
            state <= DRAIN;
          end else begin
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.slv_done_i) begin
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ame_solver_scheduler.sv
// Self-checking bench for ame_solver_scheduler. Requesters and the solver
// are modelled here; grant order, init timing, response timing and response
// contents are predicted from the scheduler's rules (round-robin pointer
// arithmetic, done/timeout cycle counts) and compared with the DUT.
module tb_ame_solver_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_BITS = 2;
  localparam int DW      = 64;
  localparam int TO      = 64;

  typedef logic [383:0]             wide_t;
  typedef logic [5:0][6:0][DW-1:0]  matrix_t;
  typedef logic [5:0][DW-1:0]       result_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model state
  int            rr_model     = 0;
  int            last_winner  = -1;
  logic [3:0]    held_mask    = '0;
  result_t       last_data    = '0;
  int            last_id      = 0;
  logic          last_timeout = 1'b0;
  matrix_t       req_mat [NUM_REQ];
  logic [3:0]    req_p6       = '0;

  ame_solver_scheduler_if #(
    .NUM_REQ(NUM_REQ), .REQ_ID_BITS(ID_BITS), .COMP_DATA_BITS(DW)
  ) bus ();

  ame_solver_scheduler #(
    .NUM_REQ(NUM_REQ), .REQ_ID_BITS(ID_BITS),
    .COMP_DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] foldMatrix(input matrix_t m);
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        f = {f[62:0], f[63]} ^ m[r[2:0]][c[2:0]];
    return f;
  endfunction

  function automatic matrix_t randomMatrix();
    logic [6*7*DW-1:0] flat;
    flat = '0;
    for (int e = 0; e < 42; e++) flat = {flat[(6*7-1)*DW-1:0], $urandom(), $urandom()};
    return matrix_t'(flat);
  endfunction

  function automatic result_t randomResult();
    logic [6*DW-1:0] flat;
    flat = '0;
    for (int e = 0; e < 6; e++) flat = {flat[5*DW-1:0], $urandom(), $urandom()};
    return result_t'(flat);
  endfunction

  function automatic int pickWinner(input logic [3:0] mask);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (rr_model + k) % NUM_REQ;
      if (mask[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge
  task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                               input logic done, input result_t data);
    @(posedge clk_i);
    #1;
    rst_i           = rst;
    bus.req_valid_i = valid;
    bus.slv_done_i  = done;
    bus.slv_data_i  = data;
    @(negedge clk_i);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},    wide_t'(bus.req_ready_o),   wide_t'(0));
    checkOutput({tag, "_init"},     wide_t'(bus.slv_init_o),    wide_t'(0));
    checkOutput({tag, "_p6"},       wide_t'(bus.slv_param6_o),  wide_t'(0));
    checkOutput({tag, "_slvdata"},  wide_t'(foldMatrix(bus.slv_data_o)), wide_t'(0));
    checkOutput({tag, "_rspvalid"}, wide_t'(bus.rsp_valid_o),   wide_t'(0));
    checkOutput({tag, "_rspid"},    wide_t'(bus.rsp_id_o),      wide_t'(0));
    checkOutput({tag, "_rspto"},    wide_t'(bus.rsp_timeout_o), wide_t'(0));
    checkOutput({tag, "_rspdata"},  wide_t'(bus.rsp_data_o),    wide_t'(0));
    checkOutput({tag, "_busy"},     wide_t'(bus.busy_o),        wide_t'(0));
  endtask

  // One full job. done_delay: cycles after the init cycle the solver answers
  // (<0 = silent). late_delay: cycle of the late done after a timeout.
  // rst_at: WAIT cycle index at which reset is pulsed (<0 = none).
  // data_mode: 0 random results, 1 pattern {1..6}<<4, 2 all zero.
  task automatic runJob(input logic [3:0] mask, input int done_delay, input int late_delay,
                        input int rst_at, input int data_mode);
    int      w;
    int      last_wait;
    logic    exp_to;
    logic [3:0] exp_ready;
    matrix_t exp_mat;
    logic    exp_p6;
    result_t res;

    // New data only for requesters not still holding an unserved request
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!held_mask[r[1:0]] || r == last_winner) begin
        req_mat[r[1:0]] = randomMatrix();
        req_p6[r[1:0]]  = 1'($urandom_range(0, 1));
      end
      bus.req_data_i[r[1:0]] = req_mat[r[1:0]];
    end
    bus.req_param6_i = req_p6;
    held_mask = mask;

    case (data_mode)
      1: for (int i = 0; i < 6; i++) res[i[2:0]] = 64'((i + 1) << 4);
      2: res = '0;
      default: res = randomResult();
    endcase

    // Arbitration cycle
    applyStimulus(1'b0, mask, 1'b0, '0);
    w = pickWinner(mask);
    exp_ready = 4'b0001 << w;
    checkOutput("idle_busy",     wide_t'(bus.busy_o),        wide_t'(0));
    checkOutput("grant",         wide_t'(bus.req_ready_o),   wide_t'(exp_ready));
    checkOutput("idle_rspvalid", wide_t'(bus.rsp_valid_o),   wide_t'(0));
    checkOutput("hold_rspid",    wide_t'(bus.rsp_id_o),      wide_t'(last_id));
    checkOutput("hold_rspto",    wide_t'(bus.rsp_timeout_o), wide_t'(last_timeout));
    checkOutput("hold_rspdata",  wide_t'(bus.rsp_data_o),    wide_t'(last_data));
    exp_mat     = req_mat[w[1:0]];
    exp_p6      = req_p6[w[1:0]];
    rr_model    = (w + 1) % NUM_REQ;
    last_winner = w;

    // Init cycle; a done pulse here must be ignored
    applyStimulus(1'b0, mask, 1'b1, randomResult());
    checkOutput("init_pulse",  wide_t'(bus.slv_init_o),   wide_t'(1));
    checkOutput("issue_ready", wide_t'(bus.req_ready_o),  wide_t'(0));
    checkOutput("issue_busy",  wide_t'(bus.busy_o),       wide_t'(1));
    checkOutput("slv_matrix",  wide_t'(foldMatrix(bus.slv_data_o)), wide_t'(foldMatrix(exp_mat)));
    checkOutput("slv_param6",  wide_t'(bus.slv_param6_o), wide_t'(exp_p6));

    exp_to    = (done_delay < 0) || (done_delay > TO);
    last_wait = exp_to ? TO : done_delay;

    for (int k = 1; k <= last_wait; k++) begin
      if (k == rst_at) begin
        applyStimulus(1'b1, mask, 1'b0, '0);
        applyStimulus(1'b0, 4'b0000, 1'b0, '0);
        checkResetState("midreset");
        rr_model     = 0;
        last_winner  = -1;
        held_mask    = '0;
        last_data    = '0;
        last_id      = 0;
        last_timeout = 1'b0;
        return;
      end
      applyStimulus(1'b0, mask, (!exp_to && k == done_delay), res);
      if (k == 1) checkOutput("init_single", wide_t'(bus.slv_init_o), wide_t'(0));
      checkOutput("wait_rspvalid", wide_t'(bus.rsp_valid_o), wide_t'(0));
      checkOutput("wait_ready",    wide_t'(bus.req_ready_o), wide_t'(0));
    end

    // Response cycle; a done pulse here must be ignored
    applyStimulus(1'b0, mask, 1'b1, randomResult());
    checkOutput("rsp_valid",   wide_t'(bus.rsp_valid_o),   wide_t'(1));
    checkOutput("rsp_id",      wide_t'(bus.rsp_id_o),      wide_t'(w));
    checkOutput("rsp_timeout", wide_t'(bus.rsp_timeout_o), wide_t'(exp_to));
    checkOutput("rsp_data",    wide_t'(bus.rsp_data_o),    exp_to ? wide_t'(0) : wide_t'(res));
    checkOutput("resp_busy",   wide_t'(bus.busy_o),        wide_t'(1));
    last_data    = exp_to ? '0 : res;
    last_id      = w;
    last_timeout = exp_to;

    // After a timeout, stay busy until the late done, whose data is dropped
    if (exp_to) begin
      for (int k = TO + 2; k <= late_delay; k++) begin
        applyStimulus(1'b0, mask, (k == late_delay), randomResult());
        checkOutput("drain_busy",     wide_t'(bus.busy_o),      wide_t'(1));
        checkOutput("drain_ready",    wide_t'(bus.req_ready_o), wide_t'(0));
        checkOutput("drain_rspvalid", wide_t'(bus.rsp_valid_o), wide_t'(0));
      end
    end
  endtask

  initial begin
    logic [3:0] mask;
    int         dly;

    bus.req_valid_i  = '0;
    bus.req_param6_i = '0;
    bus.req_data_i   = '0;
    bus.slv_done_i   = 1'b0;
    bus.slv_data_i   = '0;
    for (int r = 0; r < NUM_REQ; r++) req_mat[r[1:0]] = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, 4'b0000, 1'b0, '0);
    applyStimulus(1'b1, 4'b0000, 1'b0, '0);
    checkResetState("reset");

    $display("[TB] spurious done while idle");
    applyStimulus(1'b0, 4'b0000, 1'b1, randomResult());
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkResetState("spurious");

    $display("[TB] directed jobs");
    runJob(4'b0100, 40, 0, -1, 1);        // single request, pattern data, id 2
    runJob(4'b0001, 2, 0, -1, 2);         // singular early done with zero data
    runJob(4'b0110, TO, 0, -1, 0);        // done on the timeout cycle: done wins
    runJob(4'b1001, -1, 100, -1, 0);      // silent solver: timeout, late done at 100
    runJob(4'b1001, 5, 0, -1, 0);         // queued request granted right after drain
    runJob(4'b0100, 30, 0, 21, 0);        // reset pulsed at counter 20
    runJob(4'b1010, 3, 0, -1, 0);         // pointer restarted at 0 -> id 1
    runJob(4'b1000, 4, 0, -1, 0);         // id 3, pointer wraps to 0

    $display("[TB] fairness");
    for (int n = 0; n < 6; n++) runJob(4'b1111, int'($urandom_range(1, 20)), 0, -1, 0);

    $display("[TB] random jobs");
    for (int n = 0; n < 8; n++) begin
      mask = 4'($urandom_range(1, 15));
      dly  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO));
      runJob(mask, dly, TO + 2 + int'($urandom_range(0, 20)), -1, 0);
    end

    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("final_busy", wide_t'(bus.busy_o), wide_t'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
